// File: rtl/plb_lookup_responder_if.sv
// PLB MEM/SRAM lookup bus between the MPT walker (master) and the PLB responder (slave).
// Request and fill fields flow master->slave. Grant, response valid, data and error flow slave->master.
interface plb_lookup_responder_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                      plb_slave_mem_req;
    logic                      plb_slave_mem_gnt;
    logic                      plb_slave_mem_valid;
    logic [ADDR_WIDTH-1:0]     plb_slave_mem_addr;
    logic [DATA_WIDTH-1:0]     plb_slave_mem_rdata;
    logic [DATA_WIDTH-1:0]     plb_slave_mem_wdata;
    logic                      plb_slave_mem_we;
    logic [DATA_WIDTH/8-1:0]   plb_slave_mem_be;
    logic                      plb_slave_mem_error;

    modport master (
        output plb_slave_mem_req,
        output plb_slave_mem_addr,
        output plb_slave_mem_wdata,
        output plb_slave_mem_we,
        output plb_slave_mem_be,
        input  plb_slave_mem_gnt,
        input  plb_slave_mem_valid,
        input  plb_slave_mem_rdata,
        input  plb_slave_mem_error
    );

    modport slave (
        input  plb_slave_mem_req,
        input  plb_slave_mem_addr,
        input  plb_slave_mem_wdata,
        input  plb_slave_mem_we,
        input  plb_slave_mem_be,
        output plb_slave_mem_gnt,
        output plb_slave_mem_valid,
        output plb_slave_mem_rdata,
        output plb_slave_mem_error
    );
endinterface

// File: rtl/plb_lookup_responder.sv
// Fully-associative Protection Lookaside Buffer answering walker lookups and fills (PLB_FLUSH_EN adds flush_i).
// Latency: response valid exactly 1 cycle after each grant; one request per cycle, back-to-back supported.
// Backpressure: none, gnt follows req except during a flush cycle, when the request waits.
module plb_lookup_responder #(
    parameter int NUM_ENTRIES = 8,
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 64,
    parameter int TAG_LSB     = 12,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
`ifdef PLB_FLUSH_EN
    input  logic                     flush_i,
`endif
    plb_lookup_responder_if.slave    plb,
    output logic [CNT_WIDTH-1:0]     hit_count_o,
    output logic [CNT_WIDTH-1:0]     miss_count_o
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - TAG_LSB;

    logic                  r_vld  [NUM_ENTRIES];
    logic [TAG_W-1:0]      r_tag  [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0] r_data [NUM_ENTRIES];
    logic [IDX_W-1:0]      r_ptr;

    logic                  r_rsp_vld;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_error;
    logic [CNT_WIDTH-1:0]  r_hit_cnt;
    logic [CNT_WIDTH-1:0]  r_miss_cnt;

    logic                  w_flush;
    logic                  w_fire;
    logic                  w_lookup;
    logic                  w_fill;
    logic                  w_be_ok;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_hit;
    logic [IDX_W-1:0]      w_hit_idx;
    logic [DATA_WIDTH-1:0] w_hit_data;
    logic                  w_free;
    logic [IDX_W-1:0]      w_free_idx;
    logic                  w_wr_en;
    logic                  w_inv_en;
    logic                  w_victim;
    logic [IDX_W-1:0]      w_wr_idx;

`ifdef PLB_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif

    assign plb.plb_slave_mem_gnt = plb.plb_slave_mem_req & ~w_flush;
    assign w_fire   = plb.plb_slave_mem_req & ~w_flush;
    assign w_lookup = w_fire & ~plb.plb_slave_mem_we;
    assign w_fill   = w_fire &  plb.plb_slave_mem_we;
    assign w_be_ok  = &plb.plb_slave_mem_be;

    // Access bits below TAG_LSB are shifted out and never take part in the match.
    assign w_tag = TAG_W'(plb.plb_slave_mem_addr >> TAG_LSB);

    // Descending scan so the lowest matching / lowest free index wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_hit_data = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (r_vld[i] && (r_tag[i] == w_tag)) begin
                w_hit      = 1'b1;
                w_hit_idx  = IDX_W'(i);
                w_hit_data = r_data[i];
            end
            if (!r_vld[i]) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign w_wr_en  = w_fill & w_be_ok & (plb.plb_slave_mem_wdata != '0);
    assign w_inv_en = w_fill & w_be_ok & (plb.plb_slave_mem_wdata == '0) & w_hit;
    assign w_victim = w_wr_en & ~w_hit & ~w_free;
    assign w_wr_idx = w_hit  ? w_hit_idx  :
                      w_free ? w_free_idx : r_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_vld[i]  <= 1'b0;
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
            r_ptr <= '0;
        end else if (w_flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_vld[i] <= 1'b0;
            end
            r_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_vld[w_wr_idx]  <= 1'b1;
                r_tag[w_wr_idx]  <= w_tag;
                r_data[w_wr_idx] <= plb.plb_slave_mem_wdata;
            end
            if (w_inv_en) begin
                r_vld[w_hit_idx] <= 1'b0;
            end
            if (w_victim) begin
                r_ptr <= r_ptr + IDX_W'(1);
            end
        end
    end

    // A flush leaves the in-flight response untouched; it only blocks the new grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_vld <= 1'b0;
            r_rdata   <= '0;
            r_error   <= 1'b0;
        end else begin
            r_rsp_vld <= w_fire;
            if (w_fire) begin
                r_rdata <= (w_lookup && w_hit) ? w_hit_data : '0;
                r_error <= w_fill & ~w_be_ok;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_lookup) begin
            if (w_hit) begin
                if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_WIDTH'(1);
            end else begin
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign plb.plb_slave_mem_valid = r_rsp_vld;
    assign plb.plb_slave_mem_rdata = r_rdata;
    assign plb.plb_slave_mem_error = r_error;
    assign hit_count_o             = r_hit_cnt;
    assign miss_count_o            = r_miss_cnt;

endmodule

// File: tb/tb_plb_lookup_responder.sv
// Directed and randomized bench for plb_lookup_responder against a slot-level behavioural PLB model.
// Exercises reset, hits/misses, round-robin eviction, bad byte enables, invalidation, back-to-back and flush.
module tb_plb_lookup_responder;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n;
`ifdef PLB_FLUSH_EN
    logic        flush;
`endif
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    always #5 clk = ~clk;

    plb_lookup_responder_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    plb_lookup_responder #(
        .NUM_ENTRIES (N),
        .DATA_WIDTH  (64),
        .ADDR_WIDTH  (64),
        .TAG_LSB     (12),
        .CNT_WIDTH   (32)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
`ifdef PLB_FLUSH_EN
        .flush_i      (flush),
`endif
        .plb          (bus),
        .hit_count_o  (hit_cnt),
        .miss_count_o (miss_cnt)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: slot contents, victim pointer, counters.
    bit          m_vld  [N];
    logic [51:0] m_tag  [N];
    logic [63:0] m_data [N];
    int          m_ptr;
    logic [31:0] m_hit;
    logic [31:0] m_miss;

    logic [63:0] obs_rdata;
    logic        obs_err;
    logic [51:0] pool [12];

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", name, obs, exp);
        end
    endtask

    task automatic model_clear_entries();
        for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
        m_ptr = 0;
    endtask

    task automatic model_reset();
        model_clear_entries();
        m_hit  = '0;
        m_miss = '0;
    endtask

    function automatic int model_find(input logic [51:0] t);
        int k;
        k = -1;
        for (int i = 0; i < N; i++) if (m_vld[i] && m_tag[i] == t) k = i;
        return k;
    endfunction

    task automatic model_apply(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [7:0] be, output logic [63:0] er, output logic ee);
        logic [51:0] t;
        int k;
        t  = addr[63:12];
        er = '0;
        ee = 1'b0;
        k  = model_find(t);
        if (!we) begin
            if (k >= 0) begin
                er = m_data[k];
                if (m_hit != '1) m_hit++;
            end else if (m_miss != '1) begin
                m_miss++;
            end
        end else if (be != 8'hFF) begin
            ee = 1'b1;
        end else if (wdata == 64'd0) begin
            if (k >= 0) m_vld[k] = 1'b0;
        end else begin
            if (k < 0) begin
                for (int i = 0; i < N; i++) begin
                    if (!m_vld[i]) begin
                        k = i;
                        break;
                    end
                end
            end
            if (k < 0) begin
                k     = m_ptr;
                m_ptr = (m_ptr + 1) % N;
            end
            m_vld[k]  = 1'b1;
            m_tag[k]  = t;
            m_data[k] = wdata;
        end
    endtask

    // Called at a falling edge: drives one cycle of request, checks its response one cycle later.
    task automatic step(input bit req, input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] be, input bit fl, input string name);
        logic [63:0] er;
        logic        ee;
        bit          fire;
        bus.plb_slave_mem_req   = req;
        bus.plb_slave_mem_we    = we;
        bus.plb_slave_mem_addr  = addr;
        bus.plb_slave_mem_wdata = wdata;
        bus.plb_slave_mem_be    = be;
`ifdef PLB_FLUSH_EN
        flush = fl;
`endif
        #1;
        chk({name, "_gnt"}, 64'(bus.plb_slave_mem_gnt), 64'(req && !fl));
        fire = req && !fl;
        er   = '0;
        ee   = 1'b0;
        if (fire) model_apply(we, addr, wdata, be, er, ee);
        else if (fl) model_clear_entries();
        @(posedge clk);
        @(negedge clk);
        obs_rdata = bus.plb_slave_mem_rdata;
        obs_err   = bus.plb_slave_mem_error;
        chk({name, "_valid"}, 64'(bus.plb_slave_mem_valid), 64'(fire));
        if (fire) begin
            chk({name, "_rdata"}, obs_rdata, er);
            chk({name, "_error"}, 64'(obs_err), 64'(ee));
        end
        chk({name, "_hits"}, 64'(hit_cnt), 64'(m_hit));
        chk({name, "_misses"}, 64'(miss_cnt), 64'(m_miss));
    endtask

    function automatic logic [63:0] mk(input logic [51:0] t, input logic [11:0] lo);
        return {t, lo};
    endfunction

    initial begin
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  b;
        bit          fl;

        rst_n                   = 1'b0;
        bus.plb_slave_mem_req   = 1'b0;
        bus.plb_slave_mem_we    = 1'b0;
        bus.plb_slave_mem_addr  = '0;
        bus.plb_slave_mem_wdata = '0;
        bus.plb_slave_mem_be    = '0;
`ifdef PLB_FLUSH_EN
        flush = 1'b0;
`endif
        model_reset();
        for (int i = 0; i < 12; i++) pool[i] = 52'({$urandom, $urandom});

        repeat (2) @(negedge clk);
        chk("reset_valid", 64'(bus.plb_slave_mem_valid), 64'd0);
        chk("reset_rdata", bus.plb_slave_mem_rdata, 64'd0);
        chk("reset_error", 64'(bus.plb_slave_mem_error), 64'd0);
        chk("reset_hits", 64'(hit_cnt), 64'd0);
        chk("reset_misses", 64'(miss_cnt), 64'd0);
        chk("reset_gnt_idle", 64'(bus.plb_slave_mem_gnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill then hit with different access bits, then miss on an unfilled tag.
        step(1, 1, 64'h0100_0000_0000_5000, 64'hABCD, 8'hFF, 0, "fill_abcd");
        step(1, 0, 64'h0100_0000_0000_5003, 64'd0, 8'h00, 0, "look_abcd");
        chk("look_abcd_const", obs_rdata, 64'hABCD);
        chk("look_abcd_hitcnt", 64'(hit_cnt), 64'd1);
        step(1, 0, 64'h0200_0000_0000_7000, 64'd0, 8'h00, 0, "look_unfilled");
        chk("unfilled_const", obs_rdata, 64'd0);
        chk("unfilled_err", 64'(obs_err), 64'd0);
        chk("unfilled_misscnt", 64'(miss_cnt), 64'd1);
        step(0, 0, 64'd0, 64'd0, 8'h00, 0, "idle0");

        // Reset asserted while a response is pending drops it at once.
        bus.plb_slave_mem_req  = 1'b1;
        bus.plb_slave_mem_we   = 1'b0;
        bus.plb_slave_mem_addr = 64'h0100_0000_0000_5000;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_valid", 64'(bus.plb_slave_mem_valid), 64'd0);
        bus.plb_slave_mem_req = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_hits_cleared", 64'(hit_cnt), 64'd0);

        // Nine distinct fills into eight entries: first tag is the round-robin victim.
        for (int i = 1; i <= 9; i++)
            step(1, 1, mk(52'h300 + 52'(i), 12'h0), 64'h1000 + 64'(i), 8'hFF, 0, "fill9");
        for (int i = 1; i <= 9; i++) begin
            step(1, 0, mk(52'h300 + 52'(i), 12'h7), 64'd0, 8'h00, 0, "look9");
            chk("look9_const", obs_rdata, (i == 1) ? 64'd0 : 64'h1000 + 64'(i));
        end
        // Tenth fill must evict entry 1 (tag 2), proving the pointer advanced to 1.
        step(1, 1, mk(52'h30A, 12'h0), 64'h100A, 8'hFF, 0, "fill10");
        step(1, 0, mk(52'h302, 12'h0), 64'd0, 8'h00, 0, "look_evicted");
        chk("evicted_const", obs_rdata, 64'd0);
        step(1, 0, mk(52'h303, 12'h0), 64'd0, 8'h00, 0, "look_kept");
        chk("kept_const", obs_rdata, 64'h1003);

        // Partial byte enables are rejected; zero-fill invalidates.
        step(1, 1, mk(52'h400, 12'h0), 64'h5, 8'hF0, 0, "fill_badbe");
        chk("badbe_err_const", 64'(obs_err), 64'd1);
        step(1, 0, mk(52'h400, 12'h0), 64'd0, 8'h00, 0, "look_badbe");
        chk("badbe_miss_const", obs_rdata, 64'd0);
        step(1, 1, mk(52'h303, 12'h0), 64'd0, 8'hFF, 0, "zero_fill");
        step(1, 0, mk(52'h303, 12'h0), 64'd0, 8'h00, 0, "look_zeroed");
        chk("zeroed_const", obs_rdata, 64'd0);

        // Request held four cycles, alternating fill/lookup on one tag.
        step(1, 1, mk(52'h500, 12'h0), 64'hD1, 8'hFF, 0, "b2b_fill1");
        step(1, 0, mk(52'h500, 12'h1), 64'd0, 8'h00, 0, "b2b_look1");
        step(1, 1, mk(52'h500, 12'h0), 64'hD2, 8'hFF, 0, "b2b_fill2");
        step(1, 0, mk(52'h500, 12'h2), 64'd0, 8'h00, 0, "b2b_look2");
        chk("b2b_new_data", obs_rdata, 64'hD2);
        step(0, 0, 64'd0, 64'd0, 8'h00, 0, "idle1");

`ifdef PLB_FLUSH_EN
        step(1, 0, mk(52'h500, 12'h0), 64'd0, 8'h00, 0, "pre_flush");
        step(1, 0, mk(52'h500, 12'h0), 64'd0, 8'h00, 1, "flush");
        step(1, 0, mk(52'h500, 12'h0), 64'd0, 8'h00, 0, "post_flush");
        chk("post_flush_const", obs_rdata, 64'd0);
        step(0, 0, 64'd0, 64'd0, 8'h00, 0, "idle2");
`endif

        // Randomized traffic over a small tag pool so hits, evictions and invalidations recur.
        for (int n = 0; n < 400; n++) begin
            a = mk(pool[$urandom_range(11)], 12'($urandom));
            d = ($urandom_range(7) == 0) ? 64'd0 : {$urandom, $urandom};
            b = ($urandom_range(7) == 0) ? 8'($urandom) : 8'hFF;
            fl = 1'b0;
`ifdef PLB_FLUSH_EN
            fl = ($urandom_range(19) == 0);
`endif
            step($urandom_range(3) != 0, $urandom_range(1) == 1, a, d, b, fl, "rand");
        end
        step(0, 0, 64'd0, 64'd0, 8'h00, 0, "idle_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
